// File: rtl/attention_score_unit.sv
// Attention score: dot product of Q and K over LANES Q16.16 lanes, scaled by >>> SCALE_SHIFT, saturated to Q16.16.
// Optional feature macro ATTN_SCORE_RELU_EN: negative scores are clamped to zero before saturation.
module attention_score_unit #(
    parameter int LANES       = 6,
    parameter int SCALE_SHIFT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*32-1:0]   q_in,
    input  logic [LANES*32-1:0]   k_in,
    input  logic [LANES*32-1:0]   v_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [63:0]           attention_weight,
    output logic [LANES*32-1:0]   v_out,
    output logic                  sat_flag
);

    localparam int ACC_W = 72;
    localparam int VEC_W = LANES * 32;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SHIFT = 16 + SCALE_SHIFT;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);
    localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
    localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [VEC_W-1:0]        q_reg;
    logic [VEC_W-1:0]        k_reg;
    logic [VEC_W-1:0]        v_hold_reg;
    logic [VEC_W-1:0]        v_out_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0]        lane_reg;
    logic [63:0]             weight_reg;
    logic                    sat_reg;
    logic                    out_valid_reg;

    // Per-lane views of the captured operands
    logic signed [31:0] q_lane [LANES];
    logic signed [31:0] k_lane [LANES];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign q_lane[gi] = q_reg[gi*32 +: 32];
            assign k_lane[gi] = k_reg[gi*32 +: 32];
        end
    endgenerate

    // One shared multiplier, stepped across the lanes by lane_reg
    logic signed [31:0]      q_sel;
    logic signed [31:0]      k_sel;
    logic signed [63:0]      q_ext;
    logic signed [63:0]      k_ext;
    logic signed [63:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;

    assign q_sel    = q_lane[lane_reg];
    assign k_sel    = k_lane[lane_reg];
    assign q_ext    = {{32{q_sel[31]}}, q_sel};
    assign k_ext    = {{32{k_sel[31]}}, k_sel};
    assign prod     = q_ext * k_ext;
    assign prod_ext = {{(ACC_W-64){prod[63]}}, prod};

    // Scaling, optional ReLU and saturation of the finished accumulator
    logic signed [ACC_W-1:0] s_full;
    logic signed [ACC_W-1:0] s_clip;
    logic [31:0]             s_word;
    logic                    s_sat;

    always_comb begin
        s_full = acc_reg >>> SHIFT;
        s_clip = s_full;
`ifdef ATTN_SCORE_RELU_EN
        if (s_full[ACC_W-1]) begin
            s_clip = '0;
        end
`endif
        s_word = s_clip[31:0];
        s_sat  = 1'b0;
        if (s_clip > S_MAX) begin
            s_word = 32'h7FFF_FFFF;
            s_sat  = 1'b1;
        end else if (s_clip < S_MIN) begin
            s_word = 32'h8000_0000;
            s_sat  = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = MAC;
            MAC:     if (lane_reg == LAST_LANE) state_next = FINAL;
            FINAL:   state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg         <= '0;
            k_reg         <= '0;
            v_hold_reg    <= '0;
            v_out_reg     <= '0;
            acc_reg       <= '0;
            lane_reg      <= '0;
            weight_reg    <= '0;
            sat_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        q_reg      <= q_in;
                        k_reg      <= k_in;
                        v_hold_reg <= v_in;
                        acc_reg    <= '0;
                        lane_reg   <= '0;
                    end
                end
                MAC: begin
                    acc_reg  <= acc_reg + prod_ext;
                    lane_reg <= lane_reg + CNT_W'(1);
                end
                FINAL: begin
                    // Result registers only change here, so they hold across idle periods
                    weight_reg    <= {{32{s_word[31]}}, s_word};
                    sat_reg       <= s_sat;
                    v_out_reg     <= v_hold_reg;
                    out_valid_reg <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready         = (state_reg == IDLE);
    assign out_valid        = out_valid_reg;
    assign attention_weight = weight_reg;
    assign v_out            = v_out_reg;
    assign sat_flag         = sat_reg;

endmodule

// File: tb/tb_attention_score_unit.sv
// Self-checking bench for attention_score_unit: directed scenarios plus randomized traffic against a behavioural score model.
module tb_attention_score_unit;

    localparam int LANES = 6;
    localparam int SS    = 1;
    localparam int VW    = LANES * 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] q_in = '0;
    logic [VW-1:0] k_in = '0;
    logic [VW-1:0] v_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   attention_weight;
    logic [VW-1:0] v_out;
    logic          sat_flag;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int or_mode = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        logic [63:0]   w;
        logic [VW-1:0] v;
        logic          s;
    } res_t;

    res_t          exp_q[$];
    int            acc_edge = 0;
    res_t          last_r = '0;
    res_t          mon_r;
    logic          mon_ov;

    attention_score_unit #(.LANES(LANES), .SCALE_SHIFT(SS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .q_in(q_in),
        .k_in(k_in),
        .v_in(v_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .attention_weight(attention_weight),
        .v_out(v_out),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Score from first principles: exact dot product, floor shift, optional ReLU, clamp to 32-bit signed
    function automatic res_t ref_score(input logic [VW-1:0] q, input logic [VW-1:0] k, input logic [VW-1:0] v);
        res_t r;
        logic signed [71:0] acc;
        logic signed [71:0] sc;
        longint p;
        acc = '0;
        for (int i = 0; i < LANES; i++) begin
            p = longint'($signed(q[i*32 +: 32])) * longint'($signed(k[i*32 +: 32]));
            acc = acc + {{8{p[63]}}, p};
        end
        sc = acc >>> (16 + SS);
`ifdef ATTN_SCORE_RELU_EN
        if (sc < 0) sc = '0;
`endif
        r.v = v;
        r.s = 1'b0;
        if (sc > 72'sd2147483647) begin
            r.w = 64'h0000_0000_7FFF_FFFF;
            r.s = 1'b1;
        end else if (sc < -72'sd2147483648) begin
            r.w = 64'hFFFF_FFFF_8000_0000;
            r.s = 1'b1;
        end else begin
            r.w = sc[63:0];
        end
        return r;
    endfunction

    // Cycle-by-cycle comparison; model state advances for the coming edge
    always @(negedge clk) begin
        mon_ov = (exp_q.size() > 0) && (cyc >= acc_edge + 7);
        if (mon_en) begin
            mon_r = mon_ov ? exp_q[0] : last_r;
            check("in_ready", in_ready, exp_q.size() == 0);
            check("out_valid", out_valid, mon_ov);
            check("weight", attention_weight, mon_r.w);
            check("v_out", v_out, mon_r.v);
            check("sat_flag", sat_flag, mon_r.s);
        end
        if (!rst_n) begin
            exp_q.delete();
            last_r = '0;
        end else if (mon_ov && out_ready) begin
            last_r = exp_q.pop_front();
        end else if (in_valid && exp_q.size() == 0) begin
            exp_q.push_back(ref_score(q_in, k_in, v_in));
            acc_edge = cyc + 1;
        end
    end

    // Entered just after a rising edge; returns just after the accepting edge with in_valid still high
    task automatic send(input logic [VW-1:0] q, input logic [VW-1:0] k, input logic [VW-1:0] v, output int acc_cyc);
        int n;
        n = 0;
        in_valid = 1'b1;
        q_in = q;
        k_in = k;
        v_in = v;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=0 required=1");
        end
        acc_cyc = cyc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(output int at_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: out_valid=0 required=1");
        end
        at_cyc = cyc;
    endtask

    task automatic set_mode(input int m);
        @(negedge clk);
        or_mode = m;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rlane();
        int sel;
        sel = $urandom_range(0, 3);
        case (sel)
            0:       return $urandom();
            1:       return 32'(int'($urandom_range(0, 524288)) - 262144);
            2:       return 32'h0;
            default: return {($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000, 16'($urandom())};
        endcase
    endfunction

    function automatic logic [VW-1:0] rvec();
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*32 +: 32] = rlane();
        return r;
    endfunction

    logic [VW-1:0] ones, q2, q3, k3, va, vb, qb, kb;
    res_t er;
    int   ac, lat, prev_ac;

    initial begin
        for (int i = 0; i < LANES; i++) ones[i*32 +: 32] = 32'h0001_0000;
        q2 = '0; q2[31:0] = 32'h7FFF_0000;
        q3 = '0; q3[31:0] = 32'hFFFE_0000;
        k3 = '0; k3[31:0] = 32'h0001_0000;
        va = rvec();

        // Hand-computed values pinning the model
        er = ref_score(ones, ones, va);
        check("model_basic_w", er.w, 64'h0000_0000_0003_0000);
        check("model_basic_sat", er.s, 1'b0);
        er = ref_score(q2, q2, va);
        check("model_sat_w", er.w, 64'h0000_0000_7FFF_FFFF);
        check("model_sat_flag", er.s, 1'b1);
        er = ref_score(q3, k3, va);
`ifdef ATTN_SCORE_RELU_EN
        check("model_neg_w", er.w, 64'h0);
`else
        check("model_neg_w", er.w, 64'hFFFF_FFFF_FFFF_0000);
`endif
        check("model_neg_sat", er.s, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_weight", attention_weight, 64'h0);
        @(posedge clk);
        #1;

        // Basic
        send(ones, ones, va, ac);
        in_valid = 1'b0;
        wait_result(lat);
        check("basic_latency", lat - ac, 7);
        check("basic_w", attention_weight, 64'h0000_0000_0003_0000);
        check("basic_sat", sat_flag, 1'b0);
        check("basic_v", v_out, va);
        @(posedge clk);
        #1;

        // Saturation
        send(q2, q2, va, ac);
        in_valid = 1'b0;
        wait_result(lat);
        check("sat_w", attention_weight, 64'h0000_0000_7FFF_FFFF);
        check("sat_flag", sat_flag, 1'b1);
        @(posedge clk);
        #1;

        // Negative
        send(q3, k3, va, ac);
        in_valid = 1'b0;
        wait_result(lat);
`ifdef ATTN_SCORE_RELU_EN
        check("neg_w", attention_weight, 64'h0);
`else
        check("neg_w", attention_weight, 64'hFFFF_FFFF_FFFF_0000);
`endif
        check("neg_sat", sat_flag, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure with competing input traffic
        set_mode(2);
        qb = rvec(); kb = rvec(); vb = rvec();
        er = ref_score(qb, kb, vb);
        send(qb, kb, vb, ac);
        q_in = rvec();
        v_in = rvec();
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1'b1);
            check("bp_w", attention_weight, er.w);
            check("bp_v", v_out, vb);
            check("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        set_mode(0);
        repeat (3) @(posedge clk);
        #1;

        // Reset at E3
        send(rvec(), rvec(), rvec(), ac);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_out_valid", out_valid, 1'b0);
        check("rstmid_weight", attention_weight, 64'h0);
        check("rstmid_v", v_out, '0);
        check("rstmid_sat", sat_flag, 1'b0);
        check("rstmid_in_ready", in_ready, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        send(ones, ones, vb, ac);
        in_valid = 1'b0;
        wait_result(lat);
        check("post_rst_w", attention_weight, 64'h0000_0000_0003_0000);
        check("post_rst_v", v_out, vb);
        @(posedge clk);
        #1;

        // Throughput: in_valid held high, out_ready high
        send(rvec(), rvec(), rvec(), prev_ac);
        for (int t = 0; t < 4; t++) begin
            send(rvec(), rvec(), rvec(), ac);
            check("throughput_gap", ac - prev_ac, 9);
            prev_ac = ac;
        end
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        // Randomized traffic with random backpressure
        set_mode(1);
        for (int t = 0; t < 40; t++) begin
            send(rvec(), rvec(), rvec(), ac);
            if ($urandom_range(0, 1) != 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        set_mode(0);
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
        check("drain_empty", exp_q.size() == 0, 1'b1);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
